// File: rtl/score_tracker_if.sv
// Kill-credit handshake and HUD score bus between the score tracker and its environment.
interface score_tracker_if #(
    parameter int unsigned NUM_SRC = 4
);
    logic               Game_Restart;
    logic               Frame_Start;
    logic [NUM_SRC-1:0] Kill_Req;
    logic [NUM_SRC-1:0] Kill_Ack;
    logic [7:0]         Total_Score;
    logic [3:0]         Ten_Digit;
    logic [3:0]         Unit_Digit;
    logic               Score_Maxed;
    logic [7:0]         High_Score;

    modport master (
        output Game_Restart, Frame_Start, Kill_Req,
        input  Kill_Ack, Total_Score, Ten_Digit, Unit_Digit, Score_Maxed, High_Score
    );

    modport slave (
        input  Game_Restart, Frame_Start, Kill_Req,
        output Kill_Ack, Total_Score, Ten_Digit, Unit_Digit, Score_Maxed, High_Score
    );
endinterface

// File: rtl/score_tracker.sv
// Round-robin kill-credit arbiter feeding a saturating two-digit BCD score,
// with frame-latched display outputs and a session high score.
module score_tracker #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned MAX_SCORE = 99
) (
    input  logic            Clk,
    input  logic            Reset_n,
    score_tracker_if.slave  bus
);
    localparam int unsigned PW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [3:0]  MAX_T = 4'(MAX_SCORE / 10);
    localparam logic [3:0]  MAX_U = 4'(MAX_SCORE % 10);

    logic [NUM_SRC-1:0] r_ack;
    logic [PW-1:0]      r_ptr;
    logic [3:0]         r_run_t;
    logic [3:0]         r_run_u;
    logic [7:0]         r_total;
    logic [3:0]         r_ten;
    logic [3:0]         r_unit;
    logic               r_maxed;
    logic [7:0]         r_high;

    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_rot;
    logic               w_found;
    logic [PW-1:0]      w_gnt_idx;
    logic               w_grant;
    logic [PW-1:0]      w_next_ptr;
    logic [NUM_SRC-1:0] w_next_ack;
    logic               w_at_max;
    logic [3:0]         w_next_t;
    logic [3:0]         w_next_u;
    logic               w_next_maxed;
    logic [7:0]         w_run_bin;

    // An acked source is ineligible until it drops its request; scan rotated so bit 0 is rr_ptr.
    always_comb begin
        w_elig    = bus.Kill_Req & ~r_ack;
        w_rot     = NUM_SRC'({w_elig, w_elig} >> r_ptr);
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found   = 1'b1;
                w_gnt_idx = PW'((32'(r_ptr) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        w_grant    = w_found && !bus.Game_Restart;
        w_next_ptr = r_ptr;
        w_next_ack = '0;
        if (w_grant) begin
            w_next_ack = NUM_SRC'(1) << w_gnt_idx;
            w_next_ptr = (w_gnt_idx == PW'(NUM_SRC - 1)) ? '0 : w_gnt_idx + PW'(1);
        end
    end

    // Saturating BCD increment; a grant at the ceiling is acked but absorbed.
    always_comb begin
        w_at_max = (r_run_t == MAX_T) && (r_run_u == MAX_U);
        w_next_t = r_run_t;
        w_next_u = r_run_u;
        if (bus.Game_Restart) begin
            w_next_t = 4'd0;
            w_next_u = 4'd0;
        end else if (w_grant && !w_at_max) begin
            if (r_run_u == 4'd9) begin
                w_next_u = 4'd0;
                w_next_t = r_run_t + 4'd1;
            end else begin
                w_next_u = r_run_u + 4'd1;
            end
        end
        w_next_maxed = !bus.Game_Restart && (w_next_t == MAX_T) && (w_next_u == MAX_U);
        w_run_bin    = 8'(r_run_t) * 8'd10 + 8'(r_run_u);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ack   <= '0;
            r_ptr   <= '0;
            r_run_t <= 4'd0;
            r_run_u <= 4'd0;
            r_total <= 8'd0;
            r_ten   <= 4'd0;
            r_unit  <= 4'd0;
            r_maxed <= 1'b0;
            r_high  <= 8'd0;
        end else begin
            r_ack   <= w_next_ack;
            r_ptr   <= w_next_ptr;
            r_run_t <= w_next_t;
            r_run_u <= w_next_u;
            r_maxed <= w_next_maxed;
            // Display captures the pre-edge count so mid-frame credits never tear the HUD.
            if (bus.Frame_Start) begin
                r_total <= w_run_bin;
                r_ten   <= r_run_t;
                r_unit  <= r_run_u;
            end
            if (bus.Game_Restart && (w_run_bin > r_high)) begin
                r_high <= w_run_bin;
            end
        end
    end

    assign bus.Kill_Ack    = r_ack;
    assign bus.Total_Score = r_total;
    assign bus.Ten_Digit   = r_ten;
    assign bus.Unit_Digit  = r_unit;
    assign bus.Score_Maxed = r_maxed;
    assign bus.High_Score  = r_high;
endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed handshake scenarios plus randomized
// traffic, compared each cycle against an integer-level model of the scoring rules.
module tb_score_tracker;
    localparam int unsigned N   = 4;
    localparam int unsigned MAX = 99;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    score_tracker_if #(.NUM_SRC(N)) bus();

    score_tracker #(.NUM_SRC(N), .MAX_SCORE(MAX)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [N-1:0] req;
    logic [N-1:0] m_ack;
    int m_score, m_hs, m_disp, m_ptr, m_maxed;
    int acks_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_hs = 0; m_disp = 0; m_ptr = 0; m_maxed = 0; m_ack = '0;
    endtask

    // Scoring rules in plain integers: frame sees pre-edge count, restart wins over grants.
    task automatic model_step(input logic [N-1:0] r, input logic fs, input logic gr);
        int g;
        if (fs) m_disp = m_score;
        if (gr) begin
            if (m_score > m_hs) m_hs = m_score;
            m_score = 0;
            m_maxed = 0;
            m_ack   = '0;
        end else begin
            g = -1;
            for (int k = 0; k < int'(N); k++) begin
                int idx;
                idx = (m_ptr + k) % int'(N);
                if (g < 0 && r[idx] && !m_ack[idx]) g = idx;
            end
            m_ack = '0;
            if (g >= 0) begin
                m_ack[g] = 1'b1;
                m_ptr = (g + 1) % int'(N);
                if (m_score < int'(MAX)) m_score++;
            end
            m_maxed = (m_score == int'(MAX)) ? 1 : 0;
        end
    endtask

    task automatic compare_all();
        check("ack",    32'(bus.Kill_Ack),    32'(m_ack));
        check("total",  32'(bus.Total_Score), m_disp);
        check("ten",    32'(bus.Ten_Digit),   m_disp / 10);
        check("unit",   32'(bus.Unit_Digit),  m_disp % 10);
        check("maxed",  32'(bus.Score_Maxed), m_maxed);
        check("high",   32'(bus.High_Score),  m_hs);
    endtask

    // One clock: entered and left at a negedge; requesters drop on an observed ack.
    task automatic cycle(input logic [N-1:0] raise, input logic fs, input logic gr);
        compare_all();
        acks_seen += $countones(bus.Kill_Ack);
        for (int i = 0; i < int'(N); i++) begin
            if (bus.Kill_Ack[i]) req[i] = 1'b0;
            else if (raise[i])   req[i] = 1'b1;
        end
        bus.Kill_Req     = req;
        bus.Frame_Start  = fs;
        bus.Game_Restart = gr;
        model_step(req, fs, gr);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic give_credits(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(4'b0001, 1'b0, 1'b0);
            cycle(4'b0000, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        acks_seen = 0;
        bus.Kill_Req = '0;
        bus.Frame_Start = 1'b0;
        bus.Game_Restart = 1'b0;
        model_reset();

        @(negedge Clk);
        check("rst_ack",   32'(bus.Kill_Ack), 0);
        check("rst_total", 32'(bus.Total_Score), 0);
        check("rst_high",  32'(bus.High_Score), 0);
        check("rst_maxed", 32'(bus.Score_Maxed), 0);
        Reset_n = 1'b1;

        // Single uncontended credit.
        cycle(4'b0100, 1'b0, 1'b0);
        check("single_ack", 32'(bus.Kill_Ack), 32'h4);
        check("single_total_hold", 32'(bus.Total_Score), 0);
        cycle(4'b0000, 1'b0, 1'b0);
        check("single_ack_drop", 32'(bus.Kill_Ack), 0);
        cycle(4'b0000, 1'b1, 1'b0);
        check("single_total", 32'(bus.Total_Score), 1);
        check("single_ten", 32'(bus.Ten_Digit), 0);
        check("single_unit", 32'(bus.Unit_Digit), 1);

        // Contention with rr_ptr at 3 after granting source 2.
        cycle(4'b1111, 1'b0, 1'b0);
        check("rr_0", 32'(bus.Kill_Ack), 32'h8);
        cycle(4'b0000, 1'b0, 1'b0);
        check("rr_1", 32'(bus.Kill_Ack), 32'h1);
        cycle(4'b0000, 1'b0, 1'b0);
        check("rr_2", 32'(bus.Kill_Ack), 32'h2);
        cycle(4'b0000, 1'b0, 1'b0);
        check("rr_3", 32'(bus.Kill_Ack), 32'h4);
        cycle(4'b0000, 1'b0, 1'b0);
        check("rr_idle", 32'(bus.Kill_Ack), 0);
        cycle(4'b0000, 1'b1, 1'b0);
        check("rr_total", 32'(bus.Total_Score), 5);

        cycle(4'b0000, 1'b0, 1'b1);
        check("hs_first", 32'(bus.High_Score), 5);

        // BCD carry.
        give_credits(9);
        cycle(4'b0000, 1'b1, 1'b0);
        check("bcd9_ten", 32'(bus.Ten_Digit), 0);
        check("bcd9_unit", 32'(bus.Unit_Digit), 9);
        give_credits(1);
        cycle(4'b0000, 1'b1, 1'b0);
        check("bcd10_ten", 32'(bus.Ten_Digit), 1);
        check("bcd10_unit", 32'(bus.Unit_Digit), 0);
        check("bcd10_total", 32'(bus.Total_Score), 10);

        // Saturation: 105 handshakes, count stops at 99.
        cycle(4'b0000, 1'b0, 1'b1);
        acks_seen = 0;
        give_credits(105);
        cycle(4'b0000, 1'b1, 1'b0);
        check("sat_acks", acks_seen, 105);
        check("sat_total", 32'(bus.Total_Score), 99);
        check("sat_maxed", 32'(bus.Score_Maxed), 1);

        // Credit on the Frame_Start edge shows the pre-increment value.
        cycle(4'b0000, 1'b0, 1'b1);
        check("restart_maxed", 32'(bus.Score_Maxed), 0);
        check("restart_total_hold", 32'(bus.Total_Score), 99);
        cycle(4'b0010, 1'b1, 1'b0);
        check("same_edge_total", 32'(bus.Total_Score), 0);
        cycle(4'b0000, 1'b1, 1'b0);
        check("next_frame_total", 32'(bus.Total_Score), 1);
        cycle(4'b0000, 1'b1, 1'b1);
        check("restart_frame_pre", 32'(bus.Total_Score), 1);
        cycle(4'b0000, 1'b1, 1'b0);
        check("restart_frame_post", 32'(bus.Total_Score), 0);

        // Reset during an ack cycle; the held request is re-served once.
        cycle(4'b0001, 1'b0, 1'b0);
        check("mid_ack", 32'(bus.Kill_Ack), 32'h1);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(bus.Kill_Ack), 0);
        check("mid_rst_high", 32'(bus.High_Score), 0);
        check("mid_rst_total", 32'(bus.Total_Score), 0);
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        cycle(4'b0000, 1'b0, 1'b0);
        check("post_rst_ack", 32'(bus.Kill_Ack), 32'h1);
        cycle(4'b0000, 1'b0, 1'b0);
        check("post_rst_once", 32'(bus.Kill_Ack), 0);

        // Restart with a simultaneous request; high score tracking.
        give_credits(36);
        cycle(4'b0001, 1'b0, 1'b1);
        check("hs37_noack", 32'(bus.Kill_Ack), 0);
        check("hs37", 32'(bus.High_Score), 37);
        cycle(4'b0000, 1'b0, 1'b0);
        check("hs37_late_ack", 32'(bus.Kill_Ack), 32'h1);
        cycle(4'b0000, 1'b1, 1'b0);
        check("hs37_count1", 32'(bus.Total_Score), 1);
        give_credits(19);
        cycle(4'b0000, 1'b0, 1'b1);
        check("hs37_keep", 32'(bus.High_Score), 37);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] r;
            logic f, g;
            r = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            f = ($urandom_range(0, 15) == 0);
            g = ($urandom_range(0, 299) == 0);
            cycle(r, f, g);
        end
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
